// File: rtl/ip_mem_ctrl_pkg.sv
// Shared types for the ip_mem_ctrl_np_fo memory controller:
// op-source encoding, default read latency and the op-pipeline entry.
package ip_mem_ctrl_pkg;

  localparam int DEF_RD_LAT = 2;
  localparam int MAX_REQ    = 8;
  localparam int SRC_W      = 4;
  localparam int MAX_AW     = 32;
  localparam int MAX_DW     = 64;

  typedef logic [SRC_W-1:0] src_t;

  localparam src_t SRC_REQ0 = '0;

  function automatic src_t src_req(input int i);
    return src_t'(i);
  endfunction

  // The CPU source code sits just above the last requestor.
  function automatic src_t src_cpu(input int num_req);
    return src_t'(num_req);
  endfunction

  typedef struct packed {
    logic              vld;
    src_t              src;
    logic              rd;
    logic [MAX_AW-1:0] addr;
    logic [MAX_DW-1:0] wrData;
  } op_t;

endpackage

// File: rtl/ip_mem_ctrl_np_fo_arb.sv
// ip_rr_arb: round-robin arbiter with pointer register.
// block_i suppresses all grants and freezes the pointer.
module ip_rr_arb
  import ip_mem_ctrl_pkg::*;
#(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          block_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int off = 0; off < N; off++) begin
      j = (int'(ptr_q) + off) % N;
      if (!any_o && !block_i && req_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
        any_o    = 1'b1;
      end
    end
    ptr_d = any_o ? PW'((int'(idx_o) + 1) % N) : ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ip_mem_ctrl_np_fo.sv
// Round-robin requestors plus low-priority CPU onto one single-port RAM,
// with read-after-write forwarding. Optional: IP_MEMCTRL_CPU_STARVE_EN.
module ip_mem_ctrl_np_fo
  import ip_mem_ctrl_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int RD_LAT       = DEF_RD_LAT,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                          clockCore,
  input  logic                          resetCore,
  input  logic [NUM_REQ-1:0]            reqVld,
  input  logic [NUM_REQ-1:0]            reqRd,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] reqAddr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqWrData,
  output logic [NUM_REQ-1:0]            reqGnt,
  output logic [NUM_REQ-1:0]            rspVld,
  output logic [DATA_WIDTH-1:0]         rspData,
  input  logic                          cpuMemReq,
  input  logic                          cpuMemRd,
  input  logic [ADDR_WIDTH-1:0]         cpuMemAddr,
  input  logic [DATA_WIDTH-1:0]         cpuMemWrData,
  output logic                          cpuMemAck,
  output logic [DATA_WIDTH-1:0]         cpuMemRdData,
  output logic                          memEnable,
  output logic                          memWr,
  output logic [ADDR_WIDTH-1:0]         memAddr,
  output logic [DATA_WIDTH-1:0]         memWrData,
  input  logic [DATA_WIDTH-1:0]         memRdData
);

  localparam int   IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam src_t SRC_CPU = src_cpu(NUM_REQ);

  if (NUM_REQ < 1 || NUM_REQ > MAX_REQ || RD_LAT < 1 || RD_LAT > 4 ||
      STARVE_LIMIT < 1 || ADDR_WIDTH > MAX_AW || DATA_WIDTH > MAX_DW)
  begin : g_bad_cfg
    $error("ip_mem_ctrl_np_fo: unsupported parameter set");
  end

  logic                  req_q, req_qq, rd_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  pend_q, busy_q;
  logic                  op_rd_q;
  logic [ADDR_WIDTH-1:0] op_addr_q;
  logic [DATA_WIDTH-1:0] op_wd_q;
  logic                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  logic               force_cpu, cpu_gnt, accept;

  op_t               pipe_q [RD_LAT];
  op_t               issue, last;
  logic [MAX_DW-1:0] fwd;

`ifdef IP_MEMCTRL_CPU_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_q;

  always_ff @(posedge clockCore) begin
    if (resetCore)                                   starve_q <= '0;
    else if (cpu_gnt)                                starve_q <= '0;
    else if (pend_q && starve_q != CW'(STARVE_LIMIT)) starve_q <= starve_q + 1'b1;
  end

  assign force_cpu = pend_q && (starve_q == CW'(STARVE_LIMIT));
`else
  assign force_cpu = 1'b0;
`endif

  ip_rr_arb #(.N(NUM_REQ)) u_arb (
    .clk_i   (clockCore),
    .rst_i   (resetCore),
    .req_i   (reqVld),
    .block_i (force_cpu),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  assign cpu_gnt = pend_q && (force_cpu || !(|reqVld));
  assign reqGnt  = arb_gnt;

  always_comb begin
    issue = '0;
    if (arb_any) begin
      issue.vld    = 1'b1;
      issue.src    = src_req(int'(arb_idx));
      issue.rd     = reqRd[arb_idx];
      issue.addr   = MAX_AW'(reqAddr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH]);
      issue.wrData = MAX_DW'(reqWrData[arb_idx*DATA_WIDTH +: DATA_WIDTH]);
    end else if (cpu_gnt) begin
      issue.vld    = 1'b1;
      issue.src    = SRC_CPU;
      issue.rd     = op_rd_q;
      issue.addr   = MAX_AW'(op_addr_q);
      issue.wrData = MAX_DW'(op_wd_q);
    end
  end

  assign memEnable = issue.vld;
  assign memWr     = issue.vld && !issue.rd;
  assign memAddr   = ADDR_WIDTH'(issue.addr);
  assign memWrData = DATA_WIDTH'(issue.wrData);

  always_ff @(posedge clockCore) begin
    if (resetCore) begin
      for (int k = 0; k < RD_LAT; k++) pipe_q[k] <= '0;
    end else begin
      pipe_q[0] <= issue;
      for (int k = 1; k < RD_LAT; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign last = pipe_q[RD_LAT-1];

  // Younger writes to the same address override RAM data; youngest wins.
  always_comb begin
    fwd = MAX_DW'(memRdData);
    for (int k = RD_LAT - 2; k >= 0; k--) begin
      if (pipe_q[k].vld && !pipe_q[k].rd && pipe_q[k].addr == last.addr)
        fwd = pipe_q[k].wrData;
    end
  end

  always_comb begin
    rspVld = '0;
    for (int i = 0; i < NUM_REQ; i++)
      rspVld[i] = last.vld && last.rd && (last.src == src_req(i));
  end

  assign rspData = DATA_WIDTH'(fwd);

  assign accept = req_q && !req_qq && !busy_q;
  assign ack_d  = (pipe_q[0].vld && pipe_q[0].src == SRC_CPU && !pipe_q[0].rd) ||
                  (last.vld && last.src == SRC_CPU && last.rd);

  always_ff @(posedge clockCore) begin
    if (resetCore) begin
      req_q     <= 1'b0;
      req_qq    <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      pend_q    <= 1'b0;
      busy_q    <= 1'b0;
      op_rd_q   <= 1'b0;
      op_addr_q <= '0;
      op_wd_q   <= '0;
      ack_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      req_q  <= cpuMemReq;
      req_qq <= req_q;
      rd_q   <= cpuMemRd;
      addr_q <= cpuMemAddr;
      ack_q  <= ack_d;
      if (accept) begin
        pend_q    <= 1'b1;
        busy_q    <= 1'b1;
        op_rd_q   <= rd_q;
        op_addr_q <= addr_q;
        op_wd_q   <= cpuMemWrData;
      end else if (cpu_gnt) begin
        pend_q <= 1'b0;
      end
      if (ack_d) busy_q <= 1'b0;
      if (last.vld && last.src == SRC_CPU && last.rd)
        rd_data_q <= DATA_WIDTH'(fwd);
    end
  end

  assign cpuMemAck    = ack_q;
  assign cpuMemRdData = rd_data_q;

`ifndef SYNTHESIS
  a_gnt_onehot: assert property (@(posedge clockCore) disable iff (resetCore)
    $onehot0(reqGnt));
  a_rsp_onehot: assert property (@(posedge clockCore) disable iff (resetCore)
    $onehot0(rspVld));
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
    a_req_hold: assert property (@(posedge clockCore) disable iff (resetCore)
      reqVld[i] && !reqGnt[i] |=> reqVld[i]);
  end
`endif

endmodule

// File: tb/tb_ip_mem_ctrl_np_fo.sv
// Directed bench for ip_mem_ctrl_np_fo (NUM_REQ=3, RD_LAT=2).
// Starvation scenario runs when IP_MEMCTRL_CPU_STARVE_EN is defined.
module tb_ip_mem_ctrl_np_fo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  reqVld = '0;
  logic [2:0]  reqRd = '0;
  logic [23:0] reqAddr = '0;
  logic [47:0] reqWrData = '0;
  logic [2:0]  reqGnt, rspVld;
  logic [15:0] rspData;
  logic        cpuMemReq = 1'b0;
  logic        cpuMemRd = 1'b0;
  logic [7:0]  cpuMemAddr = '0;
  logic [15:0] cpuMemWrData = '0;
  logic        cpuMemAck;
  logic [15:0] cpuMemRdData;
  logic        memEnable, memWr;
  logic [7:0]  memAddr;
  logic [15:0] memWrData;
  logic [15:0] memRdData;

  int nvec = 0;
  int nerr = 0;

  ip_mem_ctrl_np_fo #(
    .NUM_REQ(3), .ADDR_WIDTH(8), .DATA_WIDTH(16),
    .RD_LAT(2), .STARVE_LIMIT(4)
  ) dut (
    .clockCore(clk), .resetCore(rst),
    .reqVld(reqVld), .reqRd(reqRd), .reqAddr(reqAddr),
    .reqWrData(reqWrData), .reqGnt(reqGnt),
    .rspVld(rspVld), .rspData(rspData),
    .cpuMemReq(cpuMemReq), .cpuMemRd(cpuMemRd),
    .cpuMemAddr(cpuMemAddr), .cpuMemWrData(cpuMemWrData),
    .cpuMemAck(cpuMemAck), .cpuMemRdData(cpuMemRdData),
    .memEnable(memEnable), .memWr(memWr), .memAddr(memAddr),
    .memWrData(memWrData), .memRdData(memRdData)
  );

  always #5 clk = ~clk;

  // RAM model with two-cycle read latency.
  logic [15:0] ram [0:255];
  logic [15:0] s1;
  always @(posedge clk) begin
    if (memEnable && memWr) ram[memAddr] <= memWrData;
    s1        <= (memEnable && !memWr) ? ram[memAddr] : 16'hDEAD;
    memRdData <= s1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic clr_req();
    reqVld = '0;
    reqRd  = '0;
  endtask

  task automatic set_req(input int i, input logic rd,
                         input logic [7:0] a, input logic [15:0] d);
    reqVld[i]            = 1'b1;
    reqRd[i]             = rd;
    reqAddr[i*8 +: 8]    = a;
    reqWrData[i*16 +: 16] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clr_req();
    cpuMemReq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk); #1;
    nvec++; if (reqGnt !== 3'b000) begin
      $display("FAIL rst_gnt: got %b want 000", reqGnt); nerr++; end
    nvec++; if (rspVld !== 3'b000) begin
      $display("FAIL rst_rspvld: got %b want 000", rspVld); nerr++; end
    nvec++; if (memEnable !== 1'b0) begin
      $display("FAIL rst_memen: got %b want 0", memEnable); nerr++; end
    nvec++; if (cpuMemAck !== 1'b0) begin
      $display("FAIL rst_ack: got %b want 0", cpuMemAck); nerr++; end
    nvec++; if (cpuMemRdData !== 16'h0000) begin
      $display("FAIL rst_cpudata: got %h want 0000", cpuMemRdData); nerr++; end
  endtask

  task automatic preload();
    @(negedge clk); clr_req(); set_req(0, 1'b0, 8'h30, 16'hC0DE);
    @(negedge clk); clr_req(); set_req(0, 1'b0, 8'h20, 16'h1111);
    @(negedge clk); clr_req();
  endtask

  task automatic test_basic();
    @(negedge clk); clr_req(); set_req(0, 1'b0, 8'h10, 16'h5A5A); #1;
    nvec++; if (reqGnt !== 3'b001) begin
      $display("FAIL basic_wr_gnt: got %b want 001", reqGnt); nerr++; end
    nvec++; if ({memEnable, memWr, memAddr, memWrData} !== {2'b11, 8'h10, 16'h5A5A}) begin
      $display("FAIL basic_wr_mem: got en=%b wr=%b a=%h d=%h want 1 1 10 5a5a",
               memEnable, memWr, memAddr, memWrData); nerr++; end
    @(negedge clk); clr_req(); set_req(0, 1'b1, 8'h10, 16'h0000); #1;
    nvec++; if (reqGnt !== 3'b001 || memWr !== 1'b0) begin
      $display("FAIL basic_rd_gnt: got gnt=%b wr=%b want 001 0", reqGnt, memWr); nerr++; end
    @(negedge clk); clr_req(); #1;
    nvec++; if (rspVld !== 3'b000) begin
      $display("FAIL basic_rsp_early: got %b want 000", rspVld); nerr++; end
    @(negedge clk); #1;
    nvec++; if (rspVld !== 3'b001 || rspData !== 16'h5A5A) begin
      $display("FAIL basic_rsp: got vld=%b d=%h want 001 5a5a", rspVld, rspData); nerr++; end
    @(negedge clk); #1;
    nvec++; if (rspVld !== 3'b000) begin
      $display("FAIL basic_rsp_once: got %b want 000", rspVld); nerr++; end
  endtask

  task automatic test_rr();
    logic [2:0] e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      for (int r = 0; r < 3; r++) set_req(r, 1'b0, 8'(8'h40 + r), 16'(i));
      #1;
      e = 3'(1 << (i % 3));
      nvec++; if (reqGnt !== e) begin
        $display("FAIL rr_order[%0d]: got %b want %b", i, reqGnt, e); nerr++; end
    end
    do_reset();
  endtask

  task automatic test_coherence();
    @(negedge clk); clr_req(); set_req(1, 1'b1, 8'h20, 16'h0000); #1;
    nvec++; if (reqGnt !== 3'b010) begin
      $display("FAIL coh_rd_gnt: got %b want 010", reqGnt); nerr++; end
    @(negedge clk); clr_req(); set_req(2, 1'b0, 8'h20, 16'hBEEF); #1;
    nvec++; if (reqGnt !== 3'b100 || memWr !== 1'b1) begin
      $display("FAIL coh_wr_gnt: got gnt=%b wr=%b want 100 1", reqGnt, memWr); nerr++; end
    @(negedge clk); clr_req(); #1;
    nvec++; if (rspVld !== 3'b010 || rspData !== 16'hBEEF) begin
      $display("FAIL coh_fwd: got vld=%b d=%h want 010 beef", rspVld, rspData); nerr++; end
    @(negedge clk); clr_req(); set_req(0, 1'b0, 8'h20, 16'h1111);
    @(negedge clk); clr_req(); set_req(1, 1'b1, 8'h20, 16'h0000); #1;
    nvec++; if (reqGnt !== 3'b010) begin
      $display("FAIL coh2_rd_gnt: got %b want 010", reqGnt); nerr++; end
    @(negedge clk); clr_req(); set_req(2, 1'b0, 8'h21, 16'h2222);
    @(negedge clk); clr_req(); #1;
    nvec++; if (rspVld !== 3'b010 || rspData !== 16'h1111) begin
      $display("FAIL coh_nofwd: got vld=%b d=%h want 010 1111", rspVld, rspData); nerr++; end
  endtask

  task automatic test_cpu_read();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        cpuMemReq = 1'b1; cpuMemRd = 1'b1; cpuMemAddr = 8'h30; cpuMemWrData = 16'h0;
      end
      clr_req(); set_req(0, 1'b0, 8'h50, 16'(i)); #1;
      nvec++; if (reqGnt !== 3'b001) begin
        $display("FAIL cpurd_stream[%0d]: got %b want 001", i, reqGnt); nerr++; end
    end
    @(negedge clk); clr_req(); #1;
    nvec++; if ({reqGnt, memEnable, memWr, memAddr} !== {3'b000, 2'b10, 8'h30}) begin
      $display("FAIL cpurd_issue: got gnt=%b en=%b wr=%b a=%h want 000 1 0 30",
               reqGnt, memEnable, memWr, memAddr); nerr++; end
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk); #1;
      nvec++; if (cpuMemAck !== 1'b0) begin
        $display("FAIL cpurd_ack_early[%0d]: got %b want 0", k, cpuMemAck); nerr++; end
    end
    @(negedge clk); #1;
    nvec++; if (cpuMemAck !== 1'b1 || cpuMemRdData !== 16'hC0DE) begin
      $display("FAIL cpurd_ack: got ack=%b d=%h want 1 c0de", cpuMemAck, cpuMemRdData); nerr++; end
    cpuMemReq = 1'b0;
    @(negedge clk); #1;
    nvec++; if (cpuMemAck !== 1'b0) begin
      $display("FAIL cpurd_ack_pulse: got %b want 0", cpuMemAck); nerr++; end
  endtask

  task automatic test_cpu_write();
    @(negedge clk);
    cpuMemReq = 1'b1; cpuMemRd = 1'b0; cpuMemAddr = 8'h31; cpuMemWrData = 16'h1234;
    @(negedge clk); #1;
    nvec++; if (memEnable !== 1'b0) begin
      $display("FAIL cpuwr_early: got en=%b want 0", memEnable); nerr++; end
    @(negedge clk); #1;
    nvec++; if ({memEnable, memWr, memAddr, memWrData} !== {2'b11, 8'h31, 16'h1234}) begin
      $display("FAIL cpuwr_issue: got en=%b wr=%b a=%h d=%h want 1 1 31 1234",
               memEnable, memWr, memAddr, memWrData); nerr++; end
    @(negedge clk); #1;
    nvec++; if (cpuMemAck !== 1'b0) begin
      $display("FAIL cpuwr_ack_early: got %b want 0", cpuMemAck); nerr++; end
    @(negedge clk); #1;
    nvec++; if (cpuMemAck !== 1'b1 || cpuMemRdData !== 16'hC0DE) begin
      $display("FAIL cpuwr_ack: got ack=%b rd=%h want 1 c0de", cpuMemAck, cpuMemRdData); nerr++; end
    cpuMemReq = 1'b0;
    @(negedge clk); #1;
    nvec++; if (cpuMemAck !== 1'b0) begin
      $display("FAIL cpuwr_ack_pulse: got %b want 0", cpuMemAck); nerr++; end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk); clr_req(); set_req(0, 1'b1, 8'h30, 16'h0000); #1;
    nvec++; if (reqGnt !== 3'b001) begin
      $display("FAIL mid_gnt: got %b want 001", reqGnt); nerr++; end
    @(negedge clk); clr_req(); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    nvec++; if (rspVld !== 3'b000) begin
      $display("FAIL mid_rsp_drop: got %b want 000", rspVld); nerr++; end
    @(negedge clk); #1;
    nvec++; if ({rspVld, cpuMemAck, cpuMemRdData} !== {3'b000, 1'b0, 16'h0000}) begin
      $display("FAIL mid_after: got vld=%b ack=%b d=%h want 000 0 0000",
               rspVld, cpuMemAck, cpuMemRdData); nerr++; end
  endtask

`ifdef IP_MEMCTRL_CPU_STARVE_EN
  task automatic test_starve();
    logic [2:0] e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        cpuMemReq = 1'b1; cpuMemRd = 1'b1; cpuMemAddr = 8'h30;
      end
      for (int r = 0; r < 3; r++) set_req(r, 1'b0, 8'(8'h40 + r), 16'(i));
      #1;
      e = 3'(1 << (i % 3));
      nvec++; if (reqGnt !== e) begin
        $display("FAIL starve_rr[%0d]: got %b want %b", i, reqGnt, e); nerr++; end
    end
    @(negedge clk); #1;
    nvec++; if ({reqGnt, memEnable, memWr, memAddr} !== {3'b000, 2'b10, 8'h30}) begin
      $display("FAIL starve_force: got gnt=%b en=%b wr=%b a=%h want 000 1 0 30",
               reqGnt, memEnable, memWr, memAddr); nerr++; end
    @(negedge clk); #1;
    nvec++; if (reqGnt !== 3'b001) begin
      $display("FAIL starve_resume: got %b want 001", reqGnt); nerr++; end
    @(negedge clk); #1;
    @(negedge clk); #1;
    nvec++; if (cpuMemAck !== 1'b1 || cpuMemRdData !== 16'hC0DE) begin
      $display("FAIL starve_ack: got ack=%b d=%h want 1 c0de", cpuMemAck, cpuMemRdData); nerr++; end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    preload();
    test_basic();
    test_rr();
    test_coherence();
    test_cpu_read();
    test_cpu_write();
    test_reset_midflight();
`ifdef IP_MEMCTRL_CPU_STARVE_EN
    test_starve();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ip_mem_ctrl_np_fo.md
Name: ip_mem_ctrl_np_fo

Overview:
- Next-generation single-port, flop-in/flop-out memory controller.
- Arbitrates NUM_REQ hardware requestors, round-robin among themselves, plus one low-priority CPU port onto one single-port RAM with fixed read latency RD_LAT.
- Provides read-after-write coherence: a read returns the newest write to the same address issued inside its latency window.
- Sits between the DMA engines/descriptor logic and a shared RAM macro, replacing the single-requestor controller.

Parameters:
- NUM_REQ, 2, number of hardware requestors (1..8).
- ADDR_WIDTH, 8, memory address width.
- DATA_WIDTH, 16, memory data width.
- RD_LAT, 2, cycles from memEnable (read) to valid memRdData (1..4).
- STARVE_LIMIT, 15, CPU wait cycles before forced grant (used only with the optional feature).

Ports:
- clockCore  in  1  core clock.
- resetCore  in  1  synchronous, active-high reset.
- reqVld  in  NUM_REQ  per-requestor request; held until granted.
- reqRd  in  NUM_REQ  1=read, 0=write.
- reqAddr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requestor i occupies slice i.
- reqWrData  in  NUM_REQ*DATA_WIDTH  packed write data.
- reqGnt  out  NUM_REQ  one-hot, combinational grant.
- rspVld  out  NUM_REQ  one-hot read-data-valid.
- rspData  out  DATA_WIDTH  read data for the requestor flagged in rspVld.
- cpuMemReq  in  1  CPU request level; a rising edge starts one access.
- cpuMemRd  in  1  CPU read/write select.
- cpuMemAddr  in  ADDR_WIDTH  CPU address.
- cpuMemWrData  in  DATA_WIDTH  CPU write data.
- cpuMemAck  out  1  registered one-cycle completion pulse.
- cpuMemRdData  out  DATA_WIDTH  registered CPU read data; holds until the next CPU read.
- memEnable  out  1  RAM enable.
- memWr  out  1  RAM write.
- memAddr  out  ADDR_WIDTH  RAM address.
- memWrData  out  DATA_WIDTH  RAM write data.
- memRdData  in  DATA_WIDTH  RAM read data, RD_LAT cycles after enable.

Behaviour:
- Reset: synchronous, active-high.
  - All registered outputs and state clear to 0: cpuMemAck, cpuMemRdData, rspVld pipeline, CPU pending flag, RR pointer (points at requestor 0), starvation counter.
  - Combinational outputs follow with no request active.
  - Reset mid-operation drops every in-flight read: no rspVld or cpuMemAck appears after reset deasserts.
- Arbitration (combinational, every cycle):
  - At most one grant per cycle.
  - Among the asserted reqVld, grant the first at or after the RR pointer.
  - On a grant to requestor i, the pointer moves to i+1 mod NUM_REQ.
  - The CPU is granted only when no reqVld is asserted.
- Memory interface:
  - memEnable = any grant.
  - memWr = grant & ~rd.
  - memAddr and memWrData are muxed from the granted source.
  - Requestor writes complete in the grant cycle.
- Requestor read:
  - Granted at cycle t.
  - rspVld[i]=1 and rspData valid at cycle t+RD_LAT, for exactly one cycle.
  - Back-to-back reads from the same or different requestors are fully pipelined.
- CPU:
  - cpuMemReq, cpuMemRd and cpuMemAddr are flopped once.
  - A rising edge of the flopped cpuMemReq sets the pending flag, and the op is latched.
  - Further edges while pending or in flight are ignored.
  - When pending and granted at cycle a, pending clears.
  - CPU write: cpuMemAck pulses at a+2.
  - CPU read: cpuMemRdData is captured at a+RD_LAT, and cpuMemAck pulses at a+RD_LAT+1.
- Coherence:
  - An op pipeline of depth RD_LAT records {valid, source, rd, addr, wrData}.
  - When a read returns, it takes the wrData of the youngest write issued after it to the same address; otherwise it takes memRdData.
  - This applies to both requestor and CPU reads.
- Simultaneous events: a requestor read return and a CPU read return cannot collide, because the single-port RAM allows one issue per cycle.
- Widths: the RR pointer is $clog2(NUM_REQ) wide, minimum 1 bit. The starvation counter is $clog2(STARVE_LIMIT+1) bits and saturates.
- Assertions (translate_off):
  - reqGnt is onehot0.
  - No more than one rspVld per cycle.
  - A requestor does not drop reqVld before grant.

Optional Feature:
- IP_MEMCTRL_CPU_STARVE_EN defined:
  - The starvation counter increments each cycle the CPU is pending and not granted.
  - When it reaches STARVE_LIMIT, the CPU is granted ahead of all requestors for one cycle.
  - The counter clears on CPU grant.
- Not defined: the CPU is strictly lowest priority and may wait indefinitely. The counter logic is absent.

Decomposition:
- Package ip_mem_ctrl_pkg holds:
  - Op-source encoding: SRC_REQ0..n, SRC_CPU = NUM_REQ.
  - Default RD_LAT.
  - Pipeline-entry struct typedef {vld, src, rd, addr, wrData}.
- One sub-module, ip_rr_arb (parametrised NUM_REQ round-robin arbiter with pointer register), is instantiated once.

Test Plan:
All tests use NUM_REQ=3, RD_LAT=2.
- Basic requestor access: req0 writes 0x5A5A to addr 0x10, then reads 0x10 -> reqGnt[0] in each request cycle; rspVld[0] two cycles after the read grant with rspData=0x5A5A.
- Round-robin fairness: reqVld=3'b111 held for 6 cycles -> grant order 0,1,2,0,1,2.
- Coherence forwarding: req1 reads 0x20 (RAM holds 0x1111) at t, req2 writes 0xBEEF to 0x20 at t+1 -> rspVld[1] at t+2 with 0xBEEF. A write to 0x21 instead yields 0x1111.
- CPU blocked then served: CPU reads 0x30 (0xC0DE) while req0 streams for 5 cycles -> CPU is granted in the first idle cycle a; cpuMemAck at a+3 with cpuMemRdData=0xC0DE. A CPU write acks at a+2.
- Reset mid-flight: assert resetCore one cycle after a read grant -> no rspVld; cpuMemAck=0 and cpuMemRdData=0 after reset.
- Starvation (IP_MEMCTRL_CPU_STARVE_EN, STARVE_LIMIT=4): reqVld continuously high -> CPU is granted on its 5th pending cycle, and requestors resume the next cycle.
